// File: rtl/pipe_share_arbiter.sv
// Shares one stallable pipeline among N requesters: round-robin issue on the way in,
// and an in-order tag FIFO that steers each pipeline result back to its issuer.
module pipe_share_arbiter #(
  parameter int N     = 2,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req_valid,
  input  logic [N*WIDTH-1:0]       req_data,
  output logic [N-1:0]             req_allow,
  input  logic                     pipe_in_allow,
  output logic                     pipe_validin,
  output logic [WIDTH-1:0]         pipe_datain,
  input  logic                     pipe_validout,
  input  logic [WIDTH-1:0]         pipe_dataout,
  output logic                     pipe_out_allow,
  output logic [N-1:0]             rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic [N-1:0]             rsp_allow,
  output logic [$clog2(DEPTH):0]   inflight,
  output logic                     err
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(DEPTH);

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gnt;
  logic [IW-1:0] gnt_next;
  logic [IW-1:0] head;
  logic [IW:0]   scan_sum;
  logic [IW-1:0] scan_idx;
  logic          found;

  logic [IW-1:0] tag_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  logic any_valid;
  logic full;
  logic empty;
  logic can_issue;
  logic do_pop;

  // Search upward from rr_ptr, wrapping at N, for the first valid requester.
  always_comb begin
    gnt      = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(N)) begin
        scan_sum = scan_sum - (IW+1)'(N);
      end
      scan_idx = scan_sum[IW-1:0];
      if (!found && req_valid[scan_idx]) begin
        gnt   = scan_idx;
        found = 1'b1;
      end
    end
  end

  assign gnt_next  = (gnt == IW'(N-1)) ? '0 : gnt + 1'b1;
  assign any_valid = |req_valid;
  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head      = tag_mem[rd_ptr];

  // Outputs are qualified with rst so nothing leaks out while reset is held.
  assign can_issue      = rst & any_valid & pipe_in_allow & ~full;
  assign pipe_validin   = can_issue;
  assign pipe_datain    = can_issue ? req_data[gnt*WIDTH +: WIDTH] : '0;
  assign req_allow      = can_issue ? ({{(N-1){1'b0}}, 1'b1} << gnt) : '0;

  assign pipe_out_allow = rst & ~empty & rsp_allow[head];
  assign rsp_valid      = (rst & pipe_validout & ~empty) ? ({{(N-1){1'b0}}, 1'b1} << head) : '0;
  assign rsp_data       = pipe_dataout;
  assign do_pop         = pipe_validout & pipe_out_allow;
  assign inflight       = count;

  // Tag storage needs no reset; occupancy and pointers define what is live.
  always_ff @(posedge clk) begin
    if (can_issue) begin
      tag_mem[wr_ptr] <= gnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (can_issue) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= gnt_next;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({can_issue, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pipe_validout && empty) begin
        err <= 1'b1;
      end
    end
  end

endmodule
